// File: rtl/calc_core_seq_if.sv
// rtl/calc_core_seq_if.sv - request/response bundle for the calc_core_seq calculator core
//
// Purpose: groups the operand/opcode request and the result/status response
//          of the calculator core into one interface.
// Signals:
//   start   requester -> core   request, sampled only while the core is idle
//   op      requester -> core   00 add, 01 sub, 10 mul, 11 div
//   a       requester -> core   operand A (dividend), unsigned
//   b       requester -> core   operand B (divisor), unsigned
//   busy    core -> requester   high while calculating
//   done    core -> requester   one-cycle pulse, result/err valid
//   result  core -> requester   2*WIDTH-bit registered result
//   err     core -> requester   divide-by-zero flag, held with result
// Modports: master (operand-entry side), slave (calculator core).

interface calc_core_seq_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [1:0]           op;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   result;
   logic                 err;

   modport master (
      output start, op, a, b,
      input  busy, done, result, err
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, err
   );
endinterface

// File: rtl/calc_core_seq.sv
// rtl/calc_core_seq.sv - sequential four-function calculator core (add/sub/mul/div)
//
// Purpose: accepts two WIDTH-bit unsigned operands and an opcode through a
//          start/done handshake. Add and sub finish after one calculation
//          cycle, shift-add multiply and restoring divide after WIDTH cycles.
//          Divide by zero finishes after one cycle with err set.
// Ports:
//   clk    in   system clock, all state on rising edge
//   rst_n  in   asynchronous active-low reset, aborts any operation
//   bus    calc_core_seq_if.slave: start/op/a/b in, busy/done/result/err out
// Parameters:
//   WIDTH  operand width (>= 2); result is 2*WIDTH bits
// Build option:
//   CALC_REM_EN  when defined, divide returns the remainder in the upper
//                half of result and divide-by-zero returns a there; when
//                undefined the upper half of any divide result is zero.

module calc_core_seq #(
   parameter int WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   calc_core_seq_if.slave  bus
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t               state;
   state_t               state_next;

   logic [1:0]           op_q;
   logic [WIDTH-1:0]     a_q;      // operand A; shifts out dividend / in quotient during div
   logic [WIDTH-1:0]     b_q;
   logic [WIDTH-1:0]     rem_q;    // partial remainder for restoring divide
   logic [2*WIDTH-1:0]   acc_q;    // {partial product, remaining multiplier bits}
   logic [WIDTH-1:0]     cnt_q;
   logic [2*WIDTH-1:0]   result_q;
   logic                 err_q;

   logic                 b_zero;
   logic                 calc_last;
   logic [WIDTH:0]       sum_ext;
   logic [WIDTH:0]       diff_ext;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH:0]       div_sub;
   logic                 div_ge;
   logic [WIDTH-1:0]     rem_next;
   logic [WIDTH-1:0]     quo_next;
   logic [2*WIDTH-1:0]   result_next;

   // ------------------------------------------------------------------
   // Datapath step logic
   // ------------------------------------------------------------------
   always_comb begin
      b_zero    = (b_q == '0);
      calc_last = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                  ((op_q == OP_DIV) && b_zero) || (cnt_q == CNT_LAST);

      sum_ext   = {1'b0, a_q} + {1'b0, b_q};
      diff_ext  = {1'b0, a_q} - {1'b0, b_q};

      // Shift-add multiply: add A into the upper half when the multiplier
      // LSB (acc_q[0]) is set, then shift the whole accumulator right.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

      // Restoring divide: bring in the next dividend bit MSB first; the
      // partial remainder stays below b, so the subtracted value fits WIDTH bits.
      div_shift = {rem_q, a_q[WIDTH-1]};
      div_ge    = (div_shift >= {1'b0, b_q});
      div_sub   = div_shift - {1'b0, b_q};
      rem_next  = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
      quo_next  = {a_q[WIDTH-2:0], div_ge};

      result_next = '0;
      case (op_q)
         OP_ADD: result_next = {{(WIDTH-1){1'b0}}, sum_ext};
         OP_SUB: result_next = {{WIDTH{diff_ext[WIDTH]}}, diff_ext[WIDTH-1:0]};
         OP_MUL: result_next = mul_next;
         default: begin
            if (b_zero) begin
`ifdef CALC_REM_EN
               result_next = {a_q, {WIDTH{1'b1}}};
`else
               result_next = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
`endif
            end else begin
`ifdef CALC_REM_EN
               result_next = {rem_next, quo_next};
`else
               result_next = {{WIDTH{1'b0}}, quo_next};
`endif
            end
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CALC;
         CALC:    if (calc_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Operand capture, iteration and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rem_q    <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if ((state == IDLE) && bus.start) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            rem_q <= '0;
            acc_q <= {{WIDTH{1'b0}}, bus.b};
            cnt_q <= '0;
            err_q <= 1'b0;
         end else if (state == CALC) begin
            cnt_q <= cnt_q + WIDTH'(1);
            if (op_q == OP_MUL) begin
               acc_q <= mul_next;
            end
            if ((op_q == OP_DIV) && !b_zero) begin
               rem_q <= rem_next;
               a_q   <= quo_next;
            end
            if (calc_last) begin
               result_q <= result_next;
               err_q    <= (op_q == OP_DIV) && b_zero;
            end
         end
      end
   end

   assign bus.busy   = (state == CALC);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign bus.err    = err_q;

endmodule
